// File: rtl/div_pkg.sv
// Shared types and constants for the shift/subtract divider.
// Optional feature macro used by the divider top: DIVIDER_DIV0_EN.
package div_pkg;

  // Default operand width of the divider.
  localparam int DIV_WIDTH_DEFAULT = 8;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  // Width of an iteration counter that must hold the value width-1.
  function automatic int div_cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shift_subtract_divider_counter.sv
// Shared loadable up/down counter, used as the divider's iteration counter.
// c_end flags the terminal count: zero when counting down, all-ones when up.
module shift_subtract_divider_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic          down,
  input  logic [CW-1:0] data_in,
  output logic          c_end
);

  logic [CW-1:0] r_count;

  // Load has priority over counting; reset clears the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= data_in;
    end else if (en) begin
      if (down) begin
        r_count <= r_count - CW'(1);
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign c_end = down ? (r_count == '0) : (r_count == '1);

endmodule

// File: rtl/shift_subtract_divider.sv
// Sequential unsigned restoring divider: one quotient bit per SHIFT/SUB pair.
// Optional macro DIVIDER_DIV0_EN: detect a zero divisor at acceptance and
// finish immediately with div_by_zero set; otherwise the full iteration runs
// and naturally yields quotient all-ones, remainder = dividend.
module shift_subtract_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             d_end,
  output logic             div_by_zero
);

  localparam int CW = div_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  div_state_t       r_state;
  div_state_t       w_state_next;
  logic [WIDTH:0]   r_a;          // partial remainder, one guard bit
  logic [WIDTH-1:0] r_q;          // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_m;          // captured divisor
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic             w_accept;
  logic             w_div0_hit;
  logic             w_cnt_en;
  logic             w_cnt_end;

  assign w_accept = (r_state == IDLE) && start;

`ifdef DIVIDER_DIV0_EN
  assign w_div0_hit = w_accept && (divisor == '0);
`else
  assign w_div0_hit = 1'b0;
`endif

  // Trial subtraction; a clear sign bit means the divisor fits.
  assign w_diff = r_a - {1'b0, r_m};
  assign w_fits = ~w_diff[WIDTH];

  assign w_cnt_en = (r_state == SUB);

  shift_subtract_divider_counter #(
    .CW(CW)
  ) u_iter_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (w_accept),
    .en     (w_cnt_en),
    .down   (1'b1),
    .data_in(LAST_ITER),
    .c_end  (w_cnt_end)
  );

  // Next-state logic: SHIFT/SUB alternate until the last iteration.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = w_div0_hit ? DONE : SHIFT;
      SHIFT:   w_state_next = SUB;
      SUB:     w_state_next = w_cnt_end ? DONE : SHIFT;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: capture, shift {A,Q}, then keep or discard the trial difference.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a <= '0;
      r_q <= '0;
      r_m <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_div0_hit) begin
              r_a <= {1'b0, dividend};
              r_q <= '1;
            end else begin
              r_a <= '0;
              r_q <= dividend;
            end
            r_m <= divisor;
          end
        end
        SHIFT: begin
          // A's guard bit is always clear here, so dropping it loses nothing.
          {r_a, r_q} <= {r_a[WIDTH-1:0], r_q, 1'b0};
        end
        SUB: begin
          if (w_fits) begin
            r_a <= w_diff;
          end
          r_q[0] <= w_fits;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef DIVIDER_DIV0_EN
  logic r_div0;

  // Zero-divisor flag, refreshed on every accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div0 <= 1'b0;
    end else if (w_accept) begin
      r_div0 <= w_div0_hit;
    end
  end

  assign div_by_zero = r_div0;
`else
  assign div_by_zero = 1'b0;
`endif

  assign quotient  = r_q;
  assign remainder = r_a[WIDTH-1:0];
  assign busy      = (r_state != IDLE);
  assign d_end     = (r_state == DONE);

endmodule
